// File: rtl/fp_accum_ctrl.sv
// Streaming FP accumulator controller: buffers packet elements in a small FIFO and
// drives the adder service handshake one element at a time, with a response timeout.
module fp_accum_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        add_serv,
    output logic [31:0] op1,
    output logic [31:0] op2,
    input  logic        add_busy,
    input  logic        add_done,
    input  logic [31:0] add_result,
    output logic        sum_valid,
    output logic [31:0] sum,
    output logic        sum_err,
    input  logic        sum_ready
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_FLUSH, S_OUT} state_t;

    logic [32:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    state_t        state_q, state_d;
    logic [31:0]   acc_q, acc_d, op1_q, op1_d, op2_q, op2_d, sum_q, sum_d;
    logic          err_q, err_d, inflight_last_q, inflight_last_d;
    logic          sum_valid_q, sum_valid_d, sum_err_q, sum_err_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          full, empty, push, pop, issue_fire, head_last;
    logic [31:0]   head_data;

    assign full       = (count_q == DEPTH_C);
    assign empty      = (count_q == '0);
    assign in_ready   = !full && !rst;
    assign push       = in_valid && in_ready;
    assign head_data  = mem_q[rd_ptr_q][31:0];
    assign head_last  = mem_q[rd_ptr_q][32];
    assign issue_fire = (state_q == S_ISSUE) && !empty && !add_busy;

    // The request and its operands appear in the ISSUE cycle itself; the operand
    // registers then hold them steady through WAIT.
    assign add_serv  = issue_fire;
    assign op1       = issue_fire ? acc_q : op1_q;
    assign op2       = issue_fire ? head_data : op2_q;
    assign sum_valid = sum_valid_q;
    assign sum       = sum_q;
    assign sum_err   = sum_err_q;

    always_comb begin
        state_d         = state_q;
        acc_d           = acc_q;
        err_d           = err_q;
        op1_d           = op1_q;
        op2_d           = op2_q;
        inflight_last_d = inflight_last_q;
        timer_d         = timer_q;
        sum_valid_d     = sum_valid_q;
        sum_d           = sum_q;
        sum_err_d       = sum_err_q;
        pop             = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    acc_d   = head_data;
                    err_d   = 1'b0;
                    state_d = head_last ? S_OUT : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_fire) begin
                    pop             = 1'b1;
                    op1_d           = acc_q;
                    op2_d           = head_data;
                    inflight_last_d = head_last;
                    timer_d         = '0;
                    state_d         = S_WAIT;
                end
            end
            S_WAIT: begin
                if (add_done) begin
                    acc_d   = add_result;
                    state_d = inflight_last_q ? S_OUT : S_ISSUE;
                end else if (timer_q == TMAX) begin
                    err_d   = 1'b1;
                    state_d = inflight_last_q ? S_OUT : S_FLUSH;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_FLUSH: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_last) state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (sum_ready) begin
                    state_d     = S_IDLE;
                    sum_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Result outputs are captured once on entry to OUT and then held.
        if (state_d == S_OUT && state_q != S_OUT) begin
            sum_valid_d = 1'b1;
            sum_d       = acc_d;
            sum_err_d   = err_d;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + (AW + 1)'(1);
        if (pop && !push) count_d = count_q - (AW + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_last, in_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            acc_q           <= '0;
            err_q           <= 1'b0;
            op1_q           <= '0;
            op2_q           <= '0;
            inflight_last_q <= 1'b0;
            timer_q         <= '0;
            sum_valid_q     <= 1'b0;
            sum_q           <= '0;
            sum_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            acc_q           <= acc_d;
            err_q           <= err_d;
            op1_q           <= op1_d;
            op2_q           <= op2_d;
            inflight_last_q <= inflight_last_d;
            timer_q         <= timer_d;
            sum_valid_q     <= sum_valid_d;
            sum_q           <= sum_d;
            sum_err_q       <= sum_err_d;
        end
    end
endmodule
